// File: rtl/pc_generator_if.sv
// Bus between the core front end and pc_generator: redirect/stall requests in, fetch PC and flush control out.
interface pc_generator_if;
  localparam int unsigned XLEN = 32;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] pc;
  logic            nop;
  logic            busy;
  logic            trap;
  logic [XLEN-1:0] trap_addr;

  // Core side: issues stalls and redirects, consumes the fetch PC.
  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
    input  pc, nop, busy, trap, trap_addr
  );

  // PC generator side.
  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
    output pc, nop, busy, trap, trap_addr
  );
endinterface

// File: rtl/pc_generator.sv
// Program-counter source: sequential fetch, stall hold, and the
// RUN -> FLUSH -> WAIT redirect sequence that matches the PC pipeline's
// flush protocol (flush pulse, ignored cycle, target accepted next).
// Optional feature macro: PC_MISALIGN_TRAP_EN -- misaligned redirect
// targets load TRAP_VEC and raise a one-cycle trap with the raw target.
module pc_generator #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_generator_if.slave bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            nop_q, nop_d;
  logic            busy_q;
  logic            redirect;
  logic [XLEN-1:0] target;

  // Branch is the older instruction, so it wins over a same-cycle jump.
  assign redirect = bus.branch_taken | bus.jump;
  assign target   = bus.branch_taken ? bus.branch_target : bus.jump_target;

`ifdef PC_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
`else
  wire unused_target_lsbs = ^{TRAP_VEC, target[1:0]};
`endif

  // Next-state, next-PC and flush/trap decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    nop_d   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
`endif
    case (state_q)
      RUN: begin
        if (redirect) begin
          nop_d   = 1'b1;
          state_d = FLUSH;
`ifdef PC_MISALIGN_TRAP_EN
          if (target[1:0] != 2'b00) begin
            pc_d        = TRAP_VEC;
            trap_d      = 1'b1;
            trap_addr_d = target;
          end else begin
            pc_d = target;
          end
`else
          pc_d = {target[XLEN-1:2], 2'b00};
`endif
        end else if (!bus.stall) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      // Inputs here come from squashed instructions and are ignored.
      FLUSH:   state_d = WAIT;
      WAIT:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      nop_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      nop_q   <= nop_d;
      busy_q  <= (state_d != RUN);
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Trap pulse and captured offending target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign bus.trap      = trap_q;
  assign bus.trap_addr = trap_addr_q;
`else
  assign bus.trap      = 1'b0;
  assign bus.trap_addr = '0;
`endif

  assign bus.pc   = pc_q;
  assign bus.nop  = nop_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_pc_generator.sv
// Directed bench for pc_generator: inputs driven and outputs checked on the
// falling edge, expected values written out by hand.
module tb_pc_generator;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  pc_generator_if bus ();

  pc_generator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_nop,
                         input logic e_busy);
    chk({tag, ".pc"},   bus.pc,   e_pc);
    chk({tag, ".nop"},  32'(bus.nop),  32'(e_nop));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.jump = 1'b0;
    bus.jump_target = '0;

    repeat (2) tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.trap", 32'(bus.trap), 32'h0);
    chk("reset.trap_addr", bus.trap_addr, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch
    tick(); chk_all("seq4", 32'h4, 1'b0, 1'b0);
    tick(); chk_all("seq8", 32'h8, 1'b0, 1'b0);

    // Three stalled edges at pc=8
    bus.stall = 1'b1;
    tick(); chk("stall1", bus.pc, 32'h8);
    tick(); chk("stall2", bus.pc, 32'h8);
    tick(); chk("stall3", bus.pc, 32'h8);
    bus.stall = 1'b0;
    tick(); chk("after_stall", bus.pc, 32'hC);
    tick(); chk("seq16", bus.pc, 32'h10);

    // Branch to 0x40; jump during FLUSH/WAIT must be ignored
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    tick(); chk_all("br_flush", 32'h40, 1'b1, 1'b1);
    bus.branch_taken = 1'b0; bus.jump = 1'b1; bus.jump_target = 32'h200;
    tick(); chk_all("br_wait", 32'h40, 1'b0, 1'b1);
    tick(); chk_all("br_run", 32'h40, 1'b0, 1'b0);
    bus.jump = 1'b0;
    tick(); chk_all("br_inc", 32'h44, 1'b0, 1'b0);

    // Branch and jump together: branch wins
    bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
    bus.jump = 1'b1; bus.jump_target = 32'hC0;
    tick(); chk_all("prio", 32'h80, 1'b1, 1'b1);
    bus.branch_taken = 1'b0; bus.jump = 1'b0;
    tick(); chk("prio_w1", bus.pc, 32'h80);
    tick(); chk("prio_w2", bus.pc, 32'h80);
    tick(); chk("prio_inc", bus.pc, 32'h84);

    // Jump to the top of the address space, then wrap
    bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    tick(); chk_all("top_flush", 32'hFFFF_FFFC, 1'b1, 1'b1);
    bus.jump = 1'b0;
    tick(); tick();
    chk("top_hold", bus.pc, 32'hFFFF_FFFC);
    tick(); chk_all("wrap", 32'h0, 1'b0, 1'b0);

    // Redirect coincident with stall is taken; stall then holds after WAIT
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h300;
    tick(); chk_all("stall_br", 32'h300, 1'b1, 1'b1);
    bus.branch_taken = 1'b0;
    tick(); chk_all("stall_br_w1", 32'h300, 1'b0, 1'b1);
    tick(); chk_all("stall_br_w2", 32'h300, 1'b0, 1'b0);
    tick(); chk("stall_br_hold", bus.pc, 32'h300);
    bus.stall = 1'b0;
    tick(); chk("stall_br_inc", bus.pc, 32'h304);

    // Misaligned target 0x42
    bus.branch_taken = 1'b1; bus.branch_target = 32'h42;
    tick();
    chk_all("mis_flush", TRAP_ON ? 32'h100 : 32'h40, 1'b1, 1'b1);
    chk("mis_trap", 32'(bus.trap), TRAP_ON ? 32'h1 : 32'h0);
    chk("mis_trap_addr", bus.trap_addr, TRAP_ON ? 32'h42 : 32'h0);
    bus.branch_taken = 1'b0;
    tick();
    chk("mis_trap_pulse", 32'(bus.trap), 32'h0);
    chk("mis_trap_addr_hold", bus.trap_addr, TRAP_ON ? 32'h42 : 32'h0);
    chk_all("mis_wait", TRAP_ON ? 32'h100 : 32'h40, 1'b0, 1'b1);

    // Asynchronous reset during WAIT
    #1 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 1'b0, 1'b0);
    chk("async_rst.trap_addr", bus.trap_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); chk("rst_resume", bus.pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
